instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch stage of the multicycle RV64 core, sitting directly upstream of the `control_top` FSM and its `processing` datapath. It owns the program counter and fetches 32-bit instructions from instruction memory over a req/ack handshake that tolerates variable latency. It presents a stable instruction word and a one-cycle `instr_valid` pulse to the control FSM. It accepts branch redirects and flags stalled or misaligned fetches.

## Interface
Parameters:
- `ADDR_WIDTH`, 64: PC and instruction-address width.
- `RESET_PC`, 0: PC value after reset. Must be 4-byte aligned.
- `TIMEOUT`, 16: maximum cycles `imem_req` may stay high without `imem_ack` before a fault is raised. Legal range 1..255.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fetch_req`  in  1  control FSM requests the next instruction (INSTR_FETCH state).
- `pc_load`  in  1  redirect the PC to `pc_target` (branch taken).
- `pc_target`  in  ADDR_WIDTH  redirect address.
- `instr_valid`  out  1  one-cycle pulse: `instruction_out` holds a newly fetched word.
- `instruction_out`  out  32  last fetched instruction word.
- `pc_out`  out  ADDR_WIDTH  address of the instruction in `instruction_out`.
- `busy`  out  1  high while a fetch is outstanding (state REQ).
- `fault`  out  1  sticky flag for fetch timeout or misaligned redirect.
- `imem_req`  out  1  instruction-memory read request.
- `imem_addr`  out  ADDR_WIDTH  read address. Equal to `pc` whenever `imem_req` is high.
- `imem_ack`  in  1  memory returns data this cycle.
- `imem_rdata`  in  32  instruction word; valid when `imem_ack` is high.

## Operation
- Internal registers:
  - `pc`
  - `pc_next_pending` (ADDR_WIDTH) with flag `redirect_pending`
  - `wait_cnt` (8 bit)
- States: IDLE, REQ, FAULT.
- Reset values:
  - state IDLE, `pc`=`RESET_PC`, `pc_out`=`RESET_PC`
  - `instruction_out`=32'h00000013 (addi x0,x0,0)
  - `instr_valid`=0, `busy`=0, `fault`=0, `imem_req`=0
  - `redirect_pending`=0, `wait_cnt`=0
- IDLE:
  - `pc_load`=1 with `pc_target[1:0]`≠0: `fault`←1, go to FAULT; any concurrent `fetch_req` is dropped.
  - `pc_load`=1 with aligned target: `pc`←`pc_target`.
  - `fetch_req`=1: go to REQ. The fetch uses the post-redirect `pc` when `pc_load` is also high in the same cycle.
- REQ:
  - `imem_req`=1, `busy`=1, `imem_addr`=`pc` held stable.
  - `imem_ack`=1:
    - `instruction_out`←`imem_rdata`, `pc_out`←`pc`, `instr_valid`←1 for one cycle.
    - `pc`←`pc_next_pending` if `redirect_pending`, else `pc`+4 (wraps modulo 2^ADDR_WIDTH).
    - Clear `redirect_pending` and `wait_cnt`; go to IDLE.
  - No ack: `wait_cnt`+1. If `wait_cnt` reaches `TIMEOUT`-1 without ack, `fault`←1 and go to FAULT.
  - `pc_load` in REQ:
    - aligned target: latched into `pc_next_pending`; last write wins; never alters `imem_addr` mid-request.
    - misaligned target: `fault`←1 at once and go to FAULT.
  - `fetch_req` in REQ is ignored (not queued).
  - `pc_load` together with `imem_ack` in the same cycle: the new target wins over `pc`+4.
- FAULT:
  - `imem_req`=0, `busy`=0; `fault` held at 1.
  - All inputs are ignored. The only exit is `reset`.
- `imem_ack` while `imem_req`=0 is ignored. This covers a late ack after reset.

## Timing
- `fetch_req` sampled high at edge N → `imem_req` high from cycle N+1.
- Zero-wait memory (ack in the first REQ cycle, N+1) → `instr_valid` high during cycle N+2, with `instruction_out`/`pc_out` updated from the same edge. Minimum latency is 2 cycles from `fetch_req` to data.
- Memory with k wait cycles → `instr_valid` at N+2+k.
- `instruction_out` and `pc_out` stay stable between `instr_valid` pulses.
- Back-to-back: `fetch_req` may be reasserted in the `instr_valid` cycle (state IDLE). The next `imem_req` rises one cycle later.
- Reset mid-fetch: `imem_req` drops at the reset edge. `pc` returns to `RESET_PC`, and no `instr_valid` is produced for the aborted fetch.
- All outputs are registered. There is no combinational path from `imem_ack`/`imem_rdata` to outputs.

## Test plan
- Reset, then `fetch_req` pulse, memory acks in the same cycle with 32'h00A00093 → `imem_addr`=0; `instr_valid` at cycle +2; `instruction_out`=32'h00A00093, `pc_out`=0; `pc` becomes 4.
- Three back-to-back fetches with 3 wait cycles each → addresses 0, 4, 8. Each `instr_valid` arrives 5 cycles after its `fetch_req`; `busy` is high for 4 cycles per fetch.
- `pc_load`=1, `pc_target`=0x100 during REQ (addr 0x8, ack arrives 2 cycles later) → `imem_addr` stays 0x8; next fetch uses address 0x100, not 0xC.
- `pc_load` with `pc_target`=0x102 in IDLE → `fault`=1 next cycle; later `fetch_req` produces no `imem_req`; `reset` clears `fault`.
- Ack withheld for `TIMEOUT`=16 cycles → `fault`=1 and `imem_req`=0 after the 16th REQ cycle; a late ack changes nothing.
- Assert `reset` during the 2nd wait cycle, then ack 1 cycle later → no `instr_valid`; `pc_out`=0; `instruction_out`=32'h00000013.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch stage: PC owner and imem req/ack fetcher
//
// Purpose: holds the program counter, fetches one 32-bit word per fetch_req over
// a variable-latency req/ack handshake, applies branch redirects and flags
// fetch timeouts or misaligned redirects with a sticky fault.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   fetch_req               request the next instruction
//   pc_load, pc_target      redirect the PC (branch taken)
//   instr_valid             one-cycle pulse, new word in instruction_out
//   instruction_out, pc_out last fetched word and its address
//   busy                    fetch outstanding
//   fault                   sticky timeout / misaligned-redirect flag
//   imem_req, imem_addr     instruction-memory read request and address
//   imem_ack, imem_rdata    instruction-memory response
module instr_fetch_unit #(
  parameter int                    ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic                  pc_load,
  input  logic [ADDR_WIDTH-1:0] pc_target,
  output logic                  instr_valid,
  output logic [31:0]           instruction_out,
  output logic [ADDR_WIDTH-1:0] pc_out,
  output logic                  busy,
  output logic                  fault,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_FAULT} state_t;

  localparam logic [7:0]  TIMEOUT_LAST = 8'(TIMEOUT - 1);
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pc_out_q, pc_out_d;
  logic [31:0]           instr_q, instr_d;
  logic                  instr_valid_q, instr_valid_d;
  logic                  fault_q, fault_d;
  logic                  imem_req_q, imem_req_d;
  logic [ADDR_WIDTH-1:0] pc_next_pending_q, pc_next_pending_d;
  logic                  redirect_pending_q, redirect_pending_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic                  bad_target;

  assign bad_target = pc_load && (pc_target[1:0] != 2'b00);

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    pc_out_d           = pc_out_q;
    instr_d            = instr_q;
    instr_valid_d      = 1'b0;
    fault_d            = fault_q;
    pc_next_pending_d  = pc_next_pending_q;
    redirect_pending_d = redirect_pending_q;
    wait_cnt_d         = wait_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (bad_target) begin
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          // A same-cycle redirect takes effect before the fetch starts.
          if (pc_load) pc_d = pc_target;
          if (fetch_req) begin
            state_d    = S_REQ;
            wait_cnt_d = 8'd0;
          end
        end
      end

      S_REQ: begin
        if (bad_target) begin
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else if (imem_ack) begin
          instr_d            = imem_rdata;
          pc_out_d           = pc_q;
          instr_valid_d      = 1'b1;
          // Redirect priority: this-cycle target, then latched target, then pc+4.
          if (pc_load)                 pc_d = pc_target;
          else if (redirect_pending_q) pc_d = pc_next_pending_q;
          else                         pc_d = pc_q + ADDR_WIDTH'(4);
          redirect_pending_d = 1'b0;
          wait_cnt_d         = 8'd0;
          state_d            = S_IDLE;
        end else begin
          // pc is left untouched so imem_addr stays stable mid-request.
          if (pc_load) begin
            pc_next_pending_d  = pc_target;
            redirect_pending_d = 1'b1;
          end
          if (wait_cnt_q == TIMEOUT_LAST) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end

      S_FAULT: begin
        state_d = S_FAULT;
      end

      default: state_d = S_IDLE;
    endcase

    imem_req_d = (state_d == S_REQ);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= S_IDLE;
      pc_q               <= RESET_PC;
      pc_out_q           <= RESET_PC;
      instr_q            <= NOP_INSTR;
      instr_valid_q      <= 1'b0;
      fault_q            <= 1'b0;
      imem_req_q         <= 1'b0;
      pc_next_pending_q  <= RESET_PC;
      redirect_pending_q <= 1'b0;
      wait_cnt_q         <= 8'd0;
    end else begin
      state_q            <= state_d;
      pc_q               <= pc_d;
      pc_out_q           <= pc_out_d;
      instr_q            <= instr_d;
      instr_valid_q      <= instr_valid_d;
      fault_q            <= fault_d;
      imem_req_q         <= imem_req_d;
      pc_next_pending_q  <= pc_next_pending_d;
      redirect_pending_q <= redirect_pending_d;
      wait_cnt_q         <= wait_cnt_d;
    end
  end

  assign instr_valid     = instr_valid_q;
  assign instruction_out = instr_q;
  assign pc_out          = pc_out_q;
  assign busy            = imem_req_q;
  assign fault           = fault_q;
  assign imem_req        = imem_req_q;
  assign imem_addr       = pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic        pc_load = 1'b0;
  logic [63:0] pc_target = '0;
  logic        instr_valid;
  logic [31:0] instruction_out;
  logic [63:0] pc_out;
  logic        busy;
  logic        fault;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;

  instr_fetch_unit #(
    .ADDR_WIDTH(64),
    .RESET_PC  (64'd0),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_req      (fetch_req),
    .pc_load        (pc_load),
    .pc_target      (pc_target),
    .instr_valid    (instr_valid),
    .instruction_out(instruction_out),
    .pc_out         (pc_out),
    .busy           (busy),
    .fault          (fault),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  logic [63:0] mpc = 64'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: every instr_valid pulse must match the oldest outstanding fetch.
  always @(negedge clk) begin
    if (instr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_instr_valid actual=1 required=0");
      end else begin
        mon_e = exp_q.pop_front();
        chk("instruction_out", {32'd0, instruction_out}, {32'd0, mon_e.instr});
        chk("pc_out", pc_out, mon_e.pc);
        chk("valid_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  function automatic logic [63:0] rand_aligned();
    return {$urandom, $urandom} & ~64'd3;
  endfunction

  // One complete fetch, entered and left on a negedge in IDLE.
  task automatic do_fetch(input int waits, input bit idle_redir, input logic [63:0] idle_tgt,
                          input bit mid_redir, input logic [31:0] data);
    logic [63:0] nxt;
    fetch_req = 1'b1;
    if (idle_redir) begin
      pc_load   = 1'b1;
      pc_target = idle_tgt;
      mpc       = idle_tgt;
    end
    exp_q.push_back('{pc: mpc, instr: data, cyc: cyc + 2 + waits});
    nxt = mpc + 64'd4;
    @(negedge clk);
    for (int w = 0; w <= waits; w++) begin
      fetch_req = 1'($urandom_range(0, 1));
      pc_load   = 1'b0;
      imem_ack  = 1'b0;
      chk("req_imem_req", {63'd0, imem_req}, 64'd1);
      chk("req_imem_addr", imem_addr, mpc);
      chk("req_busy", {63'd0, busy}, 64'd1);
      if (mid_redir && ($urandom_range(0, 2) == 0)) begin
        pc_load   = 1'b1;
        pc_target = rand_aligned();
        nxt       = pc_target;
      end
      if (w == waits) begin
        imem_ack   = 1'b1;
        imem_rdata = data;
      end
      @(negedge clk);
    end
    fetch_req  = 1'b0;
    pc_load    = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
    mpc        = nxt;
    chk("done_busy", {63'd0, busy}, 64'd0);
    chk("done_imem_req", {63'd0, imem_req}, 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mpc   = 64'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_instr_valid", {63'd0, instr_valid}, 64'd0);
    chk("rst_instruction_out", {32'd0, instruction_out}, 64'h13);
    chk("rst_pc_out", pc_out, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_fault", {63'd0, fault}, 64'd0);
    chk("rst_imem_req", {63'd0, imem_req}, 64'd0);

    // Zero-wait first fetch, then three back-to-back 3-wait fetches.
    do_fetch(0, 1'b0, 64'd0, 1'b0, 32'h00A0_0093);
    for (int i = 0; i < 3; i++) do_fetch(3, 1'b0, 64'd0, 1'b0, $urandom);

    // PC wraps modulo 2^64.
    do_fetch(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, $urandom);
    do_fetch(1, 1'b0, 64'd0, 1'b0, $urandom);
    chk("wrap_pc", imem_addr, 64'd4);

    // Randomized traffic with idle and in-flight redirects.
    for (int i = 0; i < 60; i++) begin
      do_fetch($urandom_range(0, 6), ($urandom_range(0, 3) == 0), rand_aligned(),
               1'($urandom_range(0, 1)), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);

    // Reset during the second wait cycle, then a late ack.
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_ack = 1'b0;
    mpc      = 64'd0;
    chk("abort_instr_valid", {63'd0, instr_valid}, 64'd0);
    chk("abort_pc_out", pc_out, 64'd0);
    chk("abort_instruction_out", {32'd0, instruction_out}, 64'h13);
    chk("abort_imem_req", {63'd0, imem_req}, 64'd0);
    do_fetch(0, 1'b0, 64'd0, 1'b0, $urandom);

    // Misaligned redirect in IDLE with a concurrent fetch_req.
    pc_load   = 1'b1;
    pc_target = 64'h102;
    fetch_req = 1'b1;
    @(negedge clk);
    pc_load   = 1'b0;
    fetch_req = 1'b0;
    chk("mis_idle_fault", {63'd0, fault}, 64'd1);
    chk("mis_idle_imem_req", {63'd0, imem_req}, 64'd0);
    fetch_req = 1'b1;
    repeat (2) @(negedge clk);
    fetch_req = 1'b0;
    chk("mis_idle_no_req", {63'd0, imem_req}, 64'd0);
    do_reset();
    chk("mis_idle_reset_fault", {63'd0, fault}, 64'd0);

    // Misaligned redirect while a fetch is outstanding.
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    pc_load   = 1'b1;
    pc_target = 64'h206;
    @(negedge clk);
    pc_load = 1'b0;
    chk("mis_req_fault", {63'd0, fault}, 64'd1);
    chk("mis_req_imem_req", {63'd0, imem_req}, 64'd0);
    chk("mis_req_busy", {63'd0, busy}, 64'd0);
    do_reset();

    // Timeout: no ack for TIMEOUT request cycles.
    fetch_req = 1'b1;
    @(negedge clk);
    fetch_req = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      chk("to_wait_imem_req", {63'd0, imem_req}, 64'd1);
      chk("to_wait_fault", {63'd0, fault}, 64'd0);
      @(negedge clk);
    end
    chk("to_fault", {63'd0, fault}, 64'd1);
    chk("to_imem_req", {63'd0, imem_req}, 64'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    fetch_req  = 1'b1;
    @(negedge clk);
    imem_ack  = 1'b0;
    fetch_req = 1'b0;
    @(negedge clk);
    chk("to_late_fault", {63'd0, fault}, 64'd1);
    chk("to_late_imem_req", {63'd0, imem_req}, 64'd0);
    chk("to_late_pc_out", pc_out, 64'd0);
    do_reset();
    chk("to_reset_fault", {63'd0, fault}, 64'd0);
    do_fetch(2, 1'b0, 64'd0, 1'b0, $urandom);

    @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
